// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encoding,
// timeout default and the NOP-insertion constants the pipeline registers use.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  localparam int MC_TIMEOUT_DEF = 64;

  // A flushed/bubbled stage register loads this instruction with valid cleared.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic        NOP_VALID = 1'b0;

  function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the datapath (master) and the pipeline controller (slave).
// Multi-cycle handshake: ex_mc_start requests the unit from EX; mc_done is a
// single-cycle "result valid" strobe, honoured in the start cycle or while busy.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_is_jump;
  logic        ex_mc_start;
  logic        mc_done;

  logic        stall_pc;
  logic        stall_if_id;
  logic        stall_id_ex;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        bubble_ex_mem;
  logic        mc_busy;
  logic        mc_abort;
  logic        mc_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  state_t      dbg_state;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           ex_is_jump, ex_mc_start, mc_done,
    input  stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
           bubble_ex_mem, mc_busy, mc_abort, mc_err, stall_cnt, flush_cnt,
           dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_is_load,
           ex_is_jump, ex_mc_start, mc_done,
    output stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
           bubble_ex_mem, mc_busy, mc_abort, mc_err, stall_cnt, flush_cnt,
           dbg_state
  );

endinterface

// File: rtl/pipe_ctrl_hazard_cnt.sv
// 32-bit wrapping event counter with asynchronous active-low clear.
module hazard_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'd0;
    end else if (inc) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: redirect flush, multi-cycle EX stall with
// timeout, and load-use stall, plus stall/redirect performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_8 = 8'(MC_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       abort_q, abort_d;
  logic       err_q;
  logic       load_use;
  logic       flush_evt;
  logic       s_pc, s_if_id, s_id_ex, f_if_id, f_id_ex, b_ex_mem;

  assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                    (src_hit(bus.id_rs1_used, bus.id_rs1, bus.ex_rd) ||
                     src_hit(bus.id_rs2_used, bus.id_rs2, bus.ex_rd));

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    abort_d   = 1'b0;
    flush_evt = 1'b0;
    s_pc      = 1'b0;
    s_if_id   = 1'b0;
    s_id_ex   = 1'b0;
    f_if_id   = 1'b0;
    f_id_ex   = 1'b0;
    b_ex_mem  = 1'b0;
    // Controls are held low while reset is asserted, whatever the inputs.
    if (cpu_rst_n) begin
      case (state_q)
        ST_RUN: begin
          if (bus.ex_is_jump) begin
            f_if_id   = 1'b1;
            f_id_ex   = 1'b1;
            flush_evt = 1'b1;
          end else if (bus.ex_mc_start) begin
            if (!bus.mc_done) begin
              s_pc     = 1'b1;
              s_if_id  = 1'b1;
              s_id_ex  = 1'b1;
              b_ex_mem = 1'b1;
              state_d  = ST_MC_WAIT;
              wait_d   = 8'd0;
            end
          end else if (load_use) begin
            s_pc    = 1'b1;
            s_if_id = 1'b1;
            f_id_ex = 1'b1;
          end
        end
        ST_MC_WAIT: begin
          if (bus.mc_done) begin
            state_d = ST_RUN;
          end else begin
            s_pc     = 1'b1;
            s_if_id  = 1'b1;
            s_id_ex  = 1'b1;
            b_ex_mem = 1'b1;
            wait_d   = wait_q + 8'd1;
            // The bubble loaded on this last wait cycle leaves a NOP in EX/MEM.
            if (wait_d == TIMEOUT_8) begin
              state_d = ST_RUN;
              abort_d = 1'b1;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
      err_q   <= err_q | abort_d;
    end
  end

  assign bus.stall_pc      = s_pc;
  assign bus.stall_if_id   = s_if_id;
  assign bus.stall_id_ex   = s_id_ex;
  assign bus.flush_if_id   = f_if_id;
  assign bus.flush_id_ex   = f_id_ex;
  assign bus.bubble_ex_mem = b_ex_mem;
  assign bus.mc_busy       = (state_q == ST_MC_WAIT);
  assign bus.mc_abort      = abort_q;
  assign bus.mc_err        = err_q;
  assign bus.dbg_state     = state_q;

  hazard_cnt u_stall_cnt (
    .clk   (cpu_clk),
    .rst_n (cpu_rst_n),
    .inc   (s_pc),
    .cnt   (bus.stall_cnt)
  );

  hazard_cnt u_flush_cnt (
    .clk   (cpu_clk),
    .rst_n (cpu_rst_n),
    .inc   (flush_evt),
    .cnt   (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle RUN vectors from a table, then
// hand-written multi-cycle, timeout and reset-during-wait sequences.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic cpu_clk = 1'b0;
  logic cpu_rst_n;
  always #5 cpu_clk = ~cpu_clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MC_TIMEOUT(4)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       jmp;
    logic       mcs;
    logic       mcd;
    logic [5:0] exp; // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, bubble_ex_mem}
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic jmp, input logic mcs,
                       input logic mcd);
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.ex_rd       = rd;
    bus.ex_is_load  = ld;
    bus.ex_is_jump  = jmp;
    bus.ex_mc_start = mcs;
    bus.mc_done     = mcd;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [5:0] ctrl();
    return {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex,
            bus.flush_if_id, bus.flush_id_ex, bus.bubble_ex_mem};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0]  = '{"idle",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{"lu_rs2",      5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110010};
    vecs[2]  = '{"lu_rs2_unus", 5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[3]  = '{"lu_rd0",      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[4]  = '{"lu_rs1",      5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110010};
    vecs[5]  = '{"no_load",     5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[6]  = '{"jump_lu",     5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000110};
    vecs[7]  = '{"mc_fast",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
    vecs[8]  = '{"jump_mc",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000110};
    vecs[9]  = '{"after_jmc",   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[10] = '{"lu_both",     5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110010};

    cpu_rst_n = 1'b0;
    idle();
    #3;
    chk("rst_ctrl",  32'(ctrl()), 32'd0);
    chk("rst_busy",  32'(bus.mc_busy), 32'd0);
    chk("rst_abort", 32'(bus.mc_abort), 32'd0);
    chk("rst_err",   32'(bus.mc_err), 32'd0);
    chk("rst_scnt",  bus.stall_cnt, 32'd0);
    chk("rst_fcnt",  bus.flush_cnt, 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_RUN));
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;

    // Table-driven single-cycle vectors, all starting from RUN.
    for (int i = 0; i < 11; i++) begin
      @(negedge cpu_clk);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
            vecs[i].ld, vecs[i].jmp, vecs[i].mcs, vecs[i].mcd);
      #1;
      chk(vecs[i].name, 32'(ctrl()), 32'(vecs[i].exp));
      chk({vecs[i].name, "_busy"}, 32'(bus.mc_busy), 32'd0);
      exp_stall += 32'(vecs[i].exp[5]);
      exp_flush += 32'(vecs[i].jmp);
    end
    @(negedge cpu_clk);
    idle();
    #1;
    chk("tbl_scnt", bus.stall_cnt, exp_stall);
    chk("tbl_fcnt", bus.flush_cnt, exp_flush);

    // Multi-cycle, done 4 cycles after start; jump during the wait is ignored.
    @(negedge cpu_clk); bus.ex_mc_start = 1'b1; #1;
    chk("mc_c0", 32'(ctrl()), 32'b111001);
    chk("mc_c0_busy", 32'(bus.mc_busy), 32'd0);
    @(negedge cpu_clk); bus.ex_mc_start = 1'b0; #1;
    chk("mc_c1", 32'(ctrl()), 32'b111001);
    chk("mc_c1_busy", 32'(bus.mc_busy), 32'd1);
    chk("mc_c1_state", 32'(bus.dbg_state), 32'(ST_MC_WAIT));
    @(negedge cpu_clk); bus.ex_is_jump = 1'b1; #1;
    chk("mc_c2_jmp", 32'(ctrl()), 32'b111001);
    @(negedge cpu_clk); bus.ex_is_jump = 1'b0; #1;
    chk("mc_c3", 32'(ctrl()), 32'b111001);
    @(negedge cpu_clk); bus.mc_done = 1'b1; #1;
    chk("mc_c4_done", 32'(ctrl()), 32'd0);
    chk("mc_c4_busy", 32'(bus.mc_busy), 32'd1);
    @(negedge cpu_clk); bus.mc_done = 1'b0; #1;
    chk("mc_c5", 32'(ctrl()), 32'd0);
    chk("mc_c5_busy", 32'(bus.mc_busy), 32'd0);
    exp_stall += 32'd4;
    chk("mc_scnt", bus.stall_cnt, exp_stall);
    chk("mc_fcnt", bus.flush_cnt, exp_flush);
    chk("mc_err0", 32'(bus.mc_err), 32'd0);

    // Timeout with MC_TIMEOUT=4: five stall cycles, then abort pulse.
    @(negedge cpu_clk); bus.ex_mc_start = 1'b1; #1;
    chk("to_c0", 32'(ctrl()), 32'b111001);
    for (int i = 1; i <= 4; i++) begin
      @(negedge cpu_clk); bus.ex_mc_start = 1'b0; #1;
      chk($sformatf("to_c%0d", i), 32'(ctrl()), 32'b111001);
      chk($sformatf("to_c%0d_abort", i), 32'(bus.mc_abort), 32'd0);
    end
    @(negedge cpu_clk); #1;
    chk("to_c5", 32'(ctrl()), 32'd0);
    chk("to_c5_busy", 32'(bus.mc_busy), 32'd0);
    chk("to_c5_abort", 32'(bus.mc_abort), 32'd1);
    chk("to_c5_err", 32'(bus.mc_err), 32'd1);
    @(negedge cpu_clk); #1;
    chk("to_c6_abort", 32'(bus.mc_abort), 32'd0);
    chk("to_c6_err", 32'(bus.mc_err), 32'd1);
    exp_stall += 32'd5;
    chk("to_scnt", bus.stall_cnt, exp_stall);

    // Reset in the middle of a wait, with a pending done and load-use inputs.
    @(negedge cpu_clk); bus.ex_mc_start = 1'b1;
    @(negedge cpu_clk); bus.ex_mc_start = 1'b0; #1;
    chk("rw_busy", 32'(bus.mc_busy), 32'd1);
    #1;
    cpu_rst_n = 1'b0;
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rw_ctrl",  32'(ctrl()), 32'd0);
    chk("rw_busy0", 32'(bus.mc_busy), 32'd0);
    chk("rw_err",   32'(bus.mc_err), 32'd0);
    chk("rw_scnt",  bus.stall_cnt, 32'd0);
    chk("rw_fcnt",  bus.flush_cnt, 32'd0);
    @(negedge cpu_clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cpu_rst_n = 1'b1;
    #1;
    chk("rw_rel_ctrl", 32'(ctrl()), 32'd0);
    @(negedge cpu_clk); bus.mc_done = 1'b0; #1;
    chk("rw_post_busy", 32'(bus.mc_busy), 32'd0);
    chk("rw_post_state", 32'(bus.dbg_state), 32'(ST_RUN));
    chk("rw_post_scnt", bus.stall_cnt, 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
